rr_mem_arbiter: RTL

- N-port round-robin arbiter between any number of line-granular cache clients (I-cache, D-cache, prefetcher, DMA) and one downstream line port (L2 or cacheline adaptor).
- Generalised successor to the fixed two-client I/D arbiter: adds parametrised port count, widths and fair rotating priority.
- Optional performance counters.
- Sits between the L1 caches and the L2 in the cache subsystem.

---
 rtl/rr_mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: round-robin arbiter that lets NUM_PORTS line-granular cache
// clients share one downstream line port. Each grant is IDLE -> BUSY (until
// mem_resp) -> RECOVER (one cycle), so back-to-back grants are at least 3 cycles apart.
// Optional macro ARB_PERF_EN adds saturating per-client grant counters and a
// contention counter. These counters are cleared only by reset.
module rr_mem_arbiter #(
   parameter int  NUM_PORTS  = 2,
   parameter int  ADDR_WIDTH = 32,
   parameter int  LINE_WIDTH = 256,
   parameter int  CNT_WIDTH  = 32,
   localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_PORTS-1:0]             req_read,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
   output logic [LINE_WIDTH-1:0]            req_rdata,
   output logic [NUM_PORTS-1:0]             req_resp,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [LINE_WIDTH-1:0]            mem_wdata,
   input  logic [LINE_WIDTH-1:0]            mem_rdata,
   input  logic                             mem_resp,
   output logic [ID_WIDTH-1:0]              grant_id,
   output logic                             busy
`ifdef ARB_PERF_EN
   ,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]   perf_grants,
   output logic [CNT_WIDTH-1:0]             perf_conflicts
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

   state_t               state;
   logic [ID_WIDTH-1:0]  rr_ptr;
   logic [ID_WIDTH-1:0]  next_id;
   logic [ID_WIDTH-1:0]  succ_id;
   logic [NUM_PORTS-1:0] pending;
   logic                 any_pending;
   logic                 sel_read;
   logic                 sel_write;

   assign pending     = req_read | req_write;
   assign any_pending = |pending;

   // Choose the first pending client at or after rr_ptr, wrapping modulo NUM_PORTS.
   always_comb begin
      int idx;
      // NOTE: give every always_comb output a default first so no path can
      // leave it unassigned; an unassigned path infers a latch.
      next_id = rr_ptr;
      idx     = 0;
      // Scan from farthest to nearest so the nearest pending client wins.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_PORTS;
         if (pending[idx]) next_id = ID_WIDTH'(idx);
      end
   end

   // Pointer value after the current owner, used once its transaction completes.
   assign succ_id = (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;

   // Arbitration FSM: grant, hold the port until mem_resp, then one recovery cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (any_pending) begin
                  grant_id <= next_id;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  rr_ptr <= succ_id;
                  busy   <= 1'b0;
                  state  <= RECOVER;
               end
            end
            RECOVER: state <= IDLE;
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign sel_read  = req_read[grant_id];
   assign sel_write = req_write[grant_id];

   // Downstream command follows the owner live, so a dropped request stops it at once.
   // A write wins over an illegal simultaneous read.
   assign mem_read    = busy & sel_read & ~sel_write;
   assign mem_write   = busy & sel_write;
   assign mem_address = busy ? req_address[grant_id*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign mem_wdata   = busy ? req_wdata[grant_id*LINE_WIDTH +: LINE_WIDTH] : '0;
   assign req_rdata   = mem_rdata;

   // Completion goes only to the owner, only while BUSY, in the mem_resp cycle.
   always_comb begin
      req_resp = '0;
      if (busy && mem_resp) req_resp[grant_id] = 1'b1;
   end

`ifdef ARB_PERF_EN
   logic [CNT_WIDTH-1:0] grant_cnt [NUM_PORTS];
   logic                 contended;

   assign contended = ($countones(pending) > 1);

   // Saturating counters, advanced once per IDLE->BUSY grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: this small counter array is reset because it is visible on
         // ports. Large storage arrays are normally left unreset.
         for (int i = 0; i < NUM_PORTS; i++) grant_cnt[i] <= '0;
         perf_conflicts <= '0;
      end else if (state == IDLE && any_pending) begin
         if (!(&grant_cnt[next_id])) grant_cnt[next_id] <= grant_cnt[next_id] + 1'b1;
         if (contended && !(&perf_conflicts)) perf_conflicts <= perf_conflicts + 1'b1;
      end
   end

   // Pack the per-client counters onto the flat output bus.
   always_comb begin
      perf_grants = '0;
      for (int i = 0; i < NUM_PORTS; i++) perf_grants[i*CNT_WIDTH +: CNT_WIDTH] = grant_cnt[i];
   end
`endif

endmodule
